// File: rtl/den_key_pkg.sv
// Shared definitions for the DEN pushbutton conditioner.
//   key_state_t     : per-key debounce FSM state
//   DEN_*           : default timing constants derived from the 50 MHz board clock
//   cnt_width()     : counter width needed to hold values 0..max_val, never below 1 bit
package den_key_pkg;

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } key_state_t;

    localparam int DEN_CLK_HZ        = 50_000_000;
    localparam int DEN_DB_CYCLES     = DEN_CLK_HZ / 100;   // 10 ms
    localparam int DEN_REPEAT_DELAY  = DEN_CLK_HZ / 2;     // 500 ms
    localparam int DEN_REPEAT_PERIOD = DEN_CLK_HZ / 10;    // 100 ms

    // Width of a counter whose largest stored value is max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/den_key_channel.sv
// One pushbutton channel: synchroniser, debounce FSM, hold/repeat counter.
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       synchronous reset, active-low
//   key_ni       raw asynchronous key, 0 = pressed
//   level_o      debounced level, 1 = pressed (registered)
//   press_o      1-cycle strobe on accepted press (registered)
//   release_o    1-cycle strobe on accepted release (registered)
//   repeat_o     1-cycle auto-repeat strobe while held (registered)
//   press_next_o next-cycle value of press_o, so the parent can register an
//                aggregate in the same cycle as press_o
module den_key_channel
    import den_key_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = DEN_DB_CYCLES,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = DEN_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEN_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o,
    output logic press_next_o
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W    = cnt_width(DB_CYCLES - 1);
    localparam int REP_W   = cnt_width(REP_MAX - 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
    localparam logic [REP_W-1:0] REP_ALL     = '1;
    localparam logic             REP_ON      = (REPEAT_EN != 0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    key_state_t       state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;   // first repeat already emitted
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic             rep_hit_s;

    // Oldest synchroniser stage is the only one the FSM may look at.
    assign sync_s = sync_q[SYNC_STAGES-1];

    // Repeat comparison target switches from the initial delay to the period
    // after the first repeat strobe.
    assign rep_hit_s = (rep_cnt_q == (rep_first_q ? PERIOD_LAST : DELAY_LAST));

    // Next-state and strobe logic for the debounce FSM and its counters.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        repeat_d    = 1'b0;
        case (state_q)
            RELEASED: begin
                if (!sync_s) begin
                    state_d  = PRESS_DB;
                    db_cnt_d = '0;
                end else begin
                    state_d  = RELEASED;
                end
            end
            PRESS_DB: begin
                if (sync_s) begin
                    state_d = RELEASED;          // bounce: drop without a strobe
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = PRESSED;
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                // A release attempt takes priority, so no repeat can coincide
                // with the eventual release strobe.
                if (sync_s) begin
                    state_d  = RELEASE_DB;
                    db_cnt_d = '0;
                end else if (rep_hit_s) begin
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
                    repeat_d    = REP_ON;
                end else if (rep_cnt_q != REP_ALL) begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q;      // saturate, unreachable for sane params
                end
            end
            RELEASE_DB: begin
                // rep_cnt stays frozen here; a glitch resumes the hold timing.
                if (!sync_s) begin
                    state_d = PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                level_d = 1'b0;
            end
        endcase
    end

    // Synchroniser, FSM state, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q      <= '1;
            state_q     <= RELEASED;
            db_cnt_q    <= '0;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], key_ni};
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
        end
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign repeat_o     = repeat_q;
    assign press_next_o = press_d;

endmodule

// File: rtl/den_key_debounce.sv
// DEN pushbutton conditioner: turns KEY[NUM_KEYS-1:0] (active-low, bouncing,
// asynchronous) into clean level/press/release/repeat signals on CLOCK_50.
// Ports:
//   CLOCK_50     system clock, rising edge
//   RESET_N      synchronous reset, active-low
//   KEY          raw keys, 0 = pressed
//   key_level    debounced level per key, 1 = pressed
//   key_press    1-cycle strobe per key on accepted press
//   key_release  1-cycle strobe per key on accepted release
//   key_repeat   1-cycle auto-repeat strobe per key while held
//   any_press    OR of key_press, aligned with key_press
// All outputs come straight from flops.
module den_key_debounce
    import den_key_pkg::*;
#(
    parameter int NUM_KEYS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = DEN_DB_CYCLES,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = DEN_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEN_REPEAT_PERIOD
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                any_press
);

    logic [NUM_KEYS-1:0] press_next_s;
    logic                any_press_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
        den_key_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DB_CYCLES     (DB_CYCLES),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk_i        (CLOCK_50),
            .rst_ni       (RESET_N),
            .key_ni       (KEY[k]),
            .level_o      (key_level[k]),
            .press_o      (key_press[k]),
            .release_o    (key_release[k]),
            .repeat_o     (key_repeat[k]),
            .press_next_o (press_next_s[k])
        );
    end

    // Aggregate press flag, registered from the channels' next-press values
    // so it rises in the same cycle as key_press.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_next_s;
        end
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_den_key_debounce.sv
module tb_den_key_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key;
    logic [3:0] key_nr;
    logic [3:0] lvl, prs, rel, rep;
    logic       anyp;
    logic [3:0] lvl_n, prs_n, rel_n, rep_n;
    logic       anyp_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    den_key_debounce #(
        .NUM_KEYS(4), .SYNC_STAGES(2), .DB_CYCLES(4),
        .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key),
        .key_level(lvl), .key_press(prs), .key_release(rel),
        .key_repeat(rep), .any_press(anyp)
    );

    den_key_debounce #(
        .NUM_KEYS(4), .SYNC_STAGES(2), .DB_CYCLES(4),
        .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut_nr (
        .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key_nr),
        .key_level(lvl_n), .key_press(prs_n), .key_release(rel_n),
        .key_repeat(rep_n), .any_press(anyp_n)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        rst_n  = 1'b0;
        key    = 4'hF;
        key_nr = 4'hF;
        tick(3);
        chk("rst_level",   8'(lvl),  8'h00);
        chk("rst_press",   8'(prs),  8'h00);
        chk("rst_release", 8'(rel),  8'h00);
        chk("rst_repeat",  8'(rep),  8'h00);
        chk("rst_any",     8'(anyp), 8'h00);
        chk("rst_nr_level", 8'(lvl_n), 8'h00);
        rst_n = 1'b1;
        tick(2);

        // 1. Clean press on KEY[0], held 40 clocks, then released
        key = 4'b1110;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            chk($sformatf("t1_press@%0d", i),  8'(prs),  (i == 7) ? 8'h01 : 8'h00);
            chk($sformatf("t1_any@%0d", i),    8'(anyp), (i == 7) ? 8'h01 : 8'h00);
            chk($sformatf("t1_level@%0d", i),  8'(lvl),  (i >= 7) ? 8'h01 : 8'h00);
            chk($sformatf("t1_repeat@%0d", i), 8'(rep),  (i == 27 || i == 35) ? 8'h01 : 8'h00);
            chk($sformatf("t1_rel@%0d", i),    8'(rel),  8'h00);
        end
        key = 4'hF;
        for (int j = 1; j <= 10; j++) begin
            tick(1);
            chk($sformatf("t1_release@%0d", j), 8'(rel), (j == 7) ? 8'h01 : 8'h00);
            chk($sformatf("t1_rlevel@%0d", j),  8'(lvl), (j < 7) ? 8'h01 : 8'h00);
            chk($sformatf("t1_rrep@%0d", j),    8'(rep), 8'h00);
            chk($sformatf("t1_rpress@%0d", j),  8'(prs), 8'h00);
        end
        tick(5);

        // 2. Bounce on KEY[1]: low 3, high 2, low 3, high
        for (int i = 1; i <= 20; i++) begin
            key = (i <= 3 || (i >= 6 && i <= 8)) ? 4'b1101 : 4'hF;
            tick(1);
            chk($sformatf("t2_press@%0d", i), 8'(prs), 8'h00);
            chk($sformatf("t2_level@%0d", i), 8'(lvl), 8'h00);
            chk($sformatf("t2_rel@%0d", i),   8'(rel), 8'h00);
        end
        tick(3);

        // 3. KEY[2] held, 2-clock release glitch, then real release
        key = 4'b1011;
        for (int i = 1; i <= 55; i++) begin
            tick(1);
            chk($sformatf("t3_press@%0d", i),  8'(prs), (i == 7) ? 8'h04 : 8'h00);
            chk($sformatf("t3_level@%0d", i),  8'(lvl), (i >= 7 && i < 47) ? 8'h04 : 8'h00);
            chk($sformatf("t3_repeat@%0d", i), 8'(rep), (i == 30 || i == 38) ? 8'h04 : 8'h00);
            chk($sformatf("t3_rel@%0d", i),    8'(rel), (i == 47) ? 8'h04 : 8'h00);
            if (i == 15) begin
                key = 4'hF;
            end else if (i == 17) begin
                key = 4'b1011;
            end else if (i == 40) begin
                key = 4'hF;
            end
        end
        tick(3);

        // 4. All keys pressed on the same edge
        key = 4'b0000;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            chk($sformatf("t4_press@%0d", i), 8'(prs),  (i == 7) ? 8'h0F : 8'h00);
            chk($sformatf("t4_any@%0d", i),   8'(anyp), (i == 7) ? 8'h01 : 8'h00);
            chk($sformatf("t4_level@%0d", i), 8'(lvl),  (i >= 7) ? 8'h0F : 8'h00);
        end
        key = 4'hF;
        for (int j = 1; j <= 10; j++) begin
            tick(1);
            chk($sformatf("t4_release@%0d", j), 8'(rel), (j == 7) ? 8'h0F : 8'h00);
        end
        tick(3);

        // 5. Reset for 2 clocks while KEY[0] is held
        key = 4'b1110;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            chk($sformatf("t5_press@%0d", i), 8'(prs), (i == 7) ? 8'h01 : 8'h00);
        end
        rst_n = 1'b0;
        for (int i = 11; i <= 25; i++) begin
            tick(1);
            if (i == 12) begin
                rst_n = 1'b1;
            end
            chk($sformatf("t5_press@%0d", i),  8'(prs),  (i == 19) ? 8'h01 : 8'h00);
            chk($sformatf("t5_any@%0d", i),    8'(anyp), (i == 19) ? 8'h01 : 8'h00);
            chk($sformatf("t5_level@%0d", i),  8'(lvl),  (i >= 19) ? 8'h01 : 8'h00);
            chk($sformatf("t5_rel@%0d", i),    8'(rel),  8'h00);
            chk($sformatf("t5_repeat@%0d", i), 8'(rep),  8'h00);
        end
        key = 4'hF;
        for (int j = 1; j <= 10; j++) begin
            tick(1);
            chk($sformatf("t5_release@%0d", j), 8'(rel), (j == 7) ? 8'h01 : 8'h00);
        end
        tick(3);

        // 6. Repeat disabled: KEY[0] held 100 clocks
        key_nr = 4'b1110;
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            chk($sformatf("t6_press@%0d", i),  8'(prs_n),  (i == 7) ? 8'h01 : 8'h00);
            chk($sformatf("t6_any@%0d", i),    8'(anyp_n), (i == 7) ? 8'h01 : 8'h00);
            chk($sformatf("t6_level@%0d", i),  8'(lvl_n),  (i >= 7) ? 8'h01 : 8'h00);
            chk($sformatf("t6_repeat@%0d", i), 8'(rep_n),  8'h00);
        end
        key_nr = 4'hF;
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
